// File: rtl/ex_operand_stage_pkg.sv
// Shared core definitions for the operand stage: ALU op encodings and the
// forwarding-source select used by the bypass muxes.
package ex_operand_stage_pkg;

  localparam int XLEN = 32;
  localparam int REG_W = 5;
  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] EXE_ADD_OP  = 4'd0;
  localparam logic [OP_W-1:0] EXE_SUB_OP  = 4'd1;
  localparam logic [OP_W-1:0] EXE_AND_OP  = 4'd2;
  localparam logic [OP_W-1:0] EXE_OR_OP   = 4'd3;
  localparam logic [OP_W-1:0] EXE_XOR_OP  = 4'd4;
  localparam logic [OP_W-1:0] EXE_SLL_OP  = 4'd5;
  localparam logic [OP_W-1:0] EXE_SRL_OP  = 4'd6;
  localparam logic [OP_W-1:0] EXE_SRA_OP  = 4'd7;
  localparam logic [OP_W-1:0] EXE_SLT_OP  = 4'd8;
  localparam logic [OP_W-1:0] EXE_SLTU_OP = 4'd9;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/ex_operand_stage_if.sv
// Decode-to-execute bus of the operand stage, including producer bypass ports.
// Handshake: an instruction moves from decode when id_valid & id_ready & ~flush
// at a rising edge; ex_valid holds with its payload until ex_ready is seen high.
interface ex_operand_stage_if;
  import ex_operand_stage_pkg::*;

  logic                  id_valid;
  logic                  id_ready;
  logic [REG_W-1:0]      id_rs1;
  logic [REG_W-1:0]      id_rs2;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic [XLEN-1:0]       id_rs1_data;
  logic [XLEN-1:0]       id_rs2_data;
  logic [XLEN-1:0]       id_imm;
  logic [XLEN-1:0]       id_pc;
  logic                  id_use_pc;
  logic                  id_use_imm;
  logic [OP_W-1:0]       id_alu_op;
  logic [REG_W-1:0]      id_rd;
  logic                  id_rd_we;

  logic                  fwd_mem_we;
  logic                  fwd_mem_load;
  logic [REG_W-1:0]      fwd_mem_rd;
  logic [XLEN-1:0]       fwd_mem_data;
  logic                  fwd_wb_we;
  logic [REG_W-1:0]      fwd_wb_rd;
  logic [XLEN-1:0]       fwd_wb_data;

  logic                  flush;
  logic                  ex_ready;
  logic                  ex_valid;
  logic [XLEN-1:0]       ex_alu_a;
  logic [XLEN-1:0]       ex_alu_b;
  logic [OP_W-1:0]       ex_alu_op;
  logic [REG_W-1:0]      ex_rd;
  logic                  ex_rd_we;

  // Observability of the bypass decisions
  fwd_sel_e              rs1_sel;
  fwd_sel_e              rs2_sel;
  logic                  hazard;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rs1_data,
           id_rs2_data, id_imm, id_pc, id_use_pc, id_use_imm, id_alu_op,
           id_rd, id_rd_we, fwd_mem_we, fwd_mem_load, fwd_mem_rd,
           fwd_mem_data, fwd_wb_we, fwd_wb_rd, fwd_wb_data, flush, ex_ready,
    input  id_ready, ex_valid, ex_alu_a, ex_alu_b, ex_alu_op, ex_rd,
           ex_rd_we, rs1_sel, rs2_sel, hazard
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rs1_data,
           id_rs2_data, id_imm, id_pc, id_use_pc, id_use_imm, id_alu_op,
           id_rd, id_rd_we, fwd_mem_we, fwd_mem_load, fwd_mem_rd,
           fwd_mem_data, fwd_wb_we, fwd_wb_rd, fwd_wb_data, flush, ex_ready,
    output id_ready, ex_valid, ex_alu_a, ex_alu_b, ex_alu_op, ex_rd,
           ex_rd_we, rs1_sel, rs2_sel, hazard
  );

endinterface

// File: rtl/ex_operand_stage_fwd_mux.sv
// Bypass mux for one source register: MEM beats WB beats register file,
// and register 0 is never bypassed.
module fwd_mux
  import ex_operand_stage_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic [XLEN-1:0]  rf_data,
  input  logic             mem_we,
  input  logic [REG_W-1:0] mem_rd,
  input  logic [XLEN-1:0]  mem_data,
  input  logic             wb_we,
  input  logic [REG_W-1:0] wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic [XLEN-1:0]  data,
  output fwd_sel_e         sel
);

  always_comb begin
    sel  = FWD_RF;
    data = rf_data;
    if (rs != '0) begin
      if (mem_we && (mem_rd == rs)) begin
        sel  = FWD_MEM;
        data = mem_data;
      end else if (wb_we && (wb_rd == rs)) begin
        sel  = FWD_WB;
        data = wb_data;
      end
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// Operand stage between decode and execute: resolves bypassed sources,
// stalls on load-use, and registers ALU operands for the EX stage.
module ex_operand_stage
  import ex_operand_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  ex_operand_stage_if.slave  bus
);

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            hazard;
  logic            transfer;
  logic            ex_valid_q;
  logic [XLEN-1:0] alu_a_q;
  logic [XLEN-1:0] alu_b_q;
  logic [OP_W-1:0] alu_op_q;
  logic [REG_W-1:0] rd_q;
  logic            rd_we_q;

  fwd_mux u_fwd_rs1 (
    .rs       (bus.id_rs1),
    .rf_data  (bus.id_rs1_data),
    .mem_we   (bus.fwd_mem_we),
    .mem_rd   (bus.fwd_mem_rd),
    .mem_data (bus.fwd_mem_data),
    .wb_we    (bus.fwd_wb_we),
    .wb_rd    (bus.fwd_wb_rd),
    .wb_data  (bus.fwd_wb_data),
    .data     (rs1_val),
    .sel      (bus.rs1_sel)
  );

  fwd_mux u_fwd_rs2 (
    .rs       (bus.id_rs2),
    .rf_data  (bus.id_rs2_data),
    .mem_we   (bus.fwd_mem_we),
    .mem_rd   (bus.fwd_mem_rd),
    .mem_data (bus.fwd_mem_data),
    .wb_we    (bus.fwd_wb_we),
    .wb_rd    (bus.fwd_wb_rd),
    .wb_data  (bus.fwd_wb_data),
    .data     (rs2_val),
    .sel      (bus.rs2_sel)
  );

  // A load in MEM has no data yet, so a dependent instruction must wait
  assign hazard = bus.fwd_mem_we && bus.fwd_mem_load && (bus.fwd_mem_rd != '0) &&
                  ((bus.id_rs1_used && (bus.id_rs1 == bus.fwd_mem_rd)) ||
                   (bus.id_rs2_used && (bus.id_rs2 == bus.fwd_mem_rd)));

  assign op_a = bus.id_use_pc  ? bus.id_pc  : rs1_val;
  assign op_b = bus.id_use_imm ? bus.id_imm : rs2_val;

  assign bus.id_ready = bus.flush || ((!ex_valid_q || bus.ex_ready) && !hazard);
  assign transfer     = bus.id_valid && bus.id_ready && !bus.flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      rd_q       <= '0;
      rd_we_q    <= 1'b0;
    end else if (bus.flush) begin
      ex_valid_q <= 1'b0;
    end else if (transfer) begin
      ex_valid_q <= 1'b1;
      alu_a_q    <= op_a;
      alu_b_q    <= op_b;
      alu_op_q   <= bus.id_alu_op;
      rd_q       <= bus.id_rd;
      rd_we_q    <= bus.id_rd_we;
    end else if (!ex_valid_q || bus.ex_ready) begin
      ex_valid_q <= 1'b0;
    end
  end

  assign bus.hazard    = hazard;
  assign bus.ex_valid  = ex_valid_q;
  assign bus.ex_alu_a  = alu_a_q;
  assign bus.ex_alu_b  = alu_b_q;
  assign bus.ex_alu_op = alu_op_q;
  assign bus.ex_rd     = rd_q;
  assign bus.ex_rd_we  = rd_we_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for the operand stage: bypass priority, x0, load-use stall,
// downstream backpressure, flush, PC/immediate selection and reset.
module tb_ex_operand_stage;
  import ex_operand_stage_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  ex_operand_stage_if bus ();

  ex_operand_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.id_valid     = 1'b0;
    bus.id_rs1       = '0;
    bus.id_rs2       = '0;
    bus.id_rs1_used  = 1'b0;
    bus.id_rs2_used  = 1'b0;
    bus.id_rs1_data  = '0;
    bus.id_rs2_data  = '0;
    bus.id_imm       = '0;
    bus.id_pc        = '0;
    bus.id_use_pc    = 1'b0;
    bus.id_use_imm   = 1'b0;
    bus.id_alu_op    = '0;
    bus.id_rd        = '0;
    bus.id_rd_we     = 1'b0;
    bus.fwd_mem_we   = 1'b0;
    bus.fwd_mem_load = 1'b0;
    bus.fwd_mem_rd   = '0;
    bus.fwd_mem_data = '0;
    bus.fwd_wb_we    = 1'b0;
    bus.fwd_wb_rd    = '0;
    bus.fwd_wb_data  = '0;
    bus.flush        = 1'b0;
    bus.ex_ready     = 1'b1;
  endtask

  // Move to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    n_cmp++;
    if ({bus.ex_valid, bus.ex_alu_a, bus.ex_alu_b, bus.ex_alu_op, bus.ex_rd, bus.ex_rd_we} !== 75'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%0b a=%h b=%h op=%h rd=%0d we=%0b, want all 0",
               bus.ex_valid, bus.ex_alu_a, bus.ex_alu_b, bus.ex_alu_op, bus.ex_rd, bus.ex_rd_we);
    end
    bus.ex_ready = 1'b0;
    #1;
    n_cmp++;
    if (bus.id_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_id_ready: got %0b want 1", bus.id_ready);
    end
    bus.ex_ready = 1'b1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fwd_priority();
    bus.id_valid = 1'b1;
    bus.id_rs1 = 5'd5;   bus.id_rs1_used = 1'b1; bus.id_rs1_data = 32'h11;
    bus.id_rs2 = 5'd6;   bus.id_rs2_used = 1'b1; bus.id_rs2_data = 32'h22;
    bus.id_alu_op = EXE_ADD_OP; bus.id_rd = 5'd3; bus.id_rd_we = 1'b1;
    bus.fwd_mem_we = 1'b1; bus.fwd_mem_rd = 5'd5; bus.fwd_mem_data = 32'hAA;
    bus.fwd_wb_we  = 1'b1; bus.fwd_wb_rd  = 5'd5; bus.fwd_wb_data  = 32'hBB;
    tick();
    n_cmp++;
    if (bus.ex_valid !== 1'b1 || bus.ex_alu_a !== 32'hAA) begin
      n_err++;
      $display("FAIL fwd_mem_over_wb: got v=%0b a=%h want v=1 a=000000aa", bus.ex_valid, bus.ex_alu_a);
    end
    n_cmp++;
    if (bus.ex_alu_b !== 32'h22 || bus.ex_alu_op !== EXE_ADD_OP || bus.ex_rd !== 5'd3 || bus.ex_rd_we !== 1'b1) begin
      n_err++;
      $display("FAIL fwd_payload: got b=%h op=%h rd=%0d we=%0b want b=00000022 op=0 rd=3 we=1",
               bus.ex_alu_b, bus.ex_alu_op, bus.ex_rd, bus.ex_rd_we);
    end
    // WB only, also on rs2; op and rd change to prove pass-through
    bus.fwd_mem_we = 1'b0;
    bus.fwd_wb_rd = 5'd6; bus.id_alu_op = EXE_SUB_OP; bus.id_rd = 5'd9; bus.id_rd_we = 1'b0;
    tick();
    n_cmp++;
    if (bus.ex_alu_a !== 32'h11 || bus.ex_alu_b !== 32'hBB || bus.ex_alu_op !== EXE_SUB_OP ||
        bus.ex_rd !== 5'd9 || bus.ex_rd_we !== 1'b0) begin
      n_err++;
      $display("FAIL fwd_wb_rs2: got a=%h b=%h op=%h rd=%0d we=%0b want a=00000011 b=000000bb op=1 rd=9 we=0",
               bus.ex_alu_a, bus.ex_alu_b, bus.ex_alu_op, bus.ex_rd, bus.ex_rd_we);
    end
    idle_inputs();
  endtask

  task automatic test_zero_reg();
    bus.id_valid = 1'b1;
    bus.id_rs1 = 5'd0; bus.id_rs1_used = 1'b1; bus.id_rs1_data = 32'h0;
    bus.id_rs2 = 5'd0; bus.id_rs2_used = 1'b1; bus.id_rs2_data = 32'h5;
    bus.fwd_mem_we = 1'b1; bus.fwd_mem_rd = 5'd0; bus.fwd_mem_data = 32'hFF;
    bus.fwd_wb_we  = 1'b1; bus.fwd_wb_rd  = 5'd0; bus.fwd_wb_data  = 32'hEE;
    tick();
    n_cmp++;
    if (bus.ex_valid !== 1'b1 || bus.ex_alu_a !== 32'h0 || bus.ex_alu_b !== 32'h5) begin
      n_err++;
      $display("FAIL zero_no_fwd: got v=%0b a=%h b=%h want v=1 a=00000000 b=00000005",
               bus.ex_valid, bus.ex_alu_a, bus.ex_alu_b);
    end
    // A load targeting x0 must not stall
    bus.fwd_mem_load = 1'b1;
    #1;
    n_cmp++;
    if (bus.id_ready !== 1'b1) begin
      n_err++;
      $display("FAIL zero_load_no_hazard: got id_ready=%0b want 1", bus.id_ready);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_load_use();
    // Put a valid instruction in EX first so the bubble is observable
    bus.id_valid = 1'b1; bus.id_rs1_data = 32'h77;
    tick();
    bus.id_rs1 = 5'd2; bus.id_rs1_used = 1'b1; bus.id_rs1_data = 32'h3;
    bus.id_rs2 = 5'd7; bus.id_rs2_used = 1'b1; bus.id_rs2_data = 32'h9;
    bus.fwd_mem_we = 1'b1; bus.fwd_mem_load = 1'b1; bus.fwd_mem_rd = 5'd7; bus.fwd_mem_data = 32'hDEAD;
    #1;
    n_cmp++;
    if (bus.id_ready !== 1'b0) begin
      n_err++;
      $display("FAIL load_use_ready: got id_ready=%0b want 0", bus.id_ready);
    end
    tick();
    n_cmp++;
    if (bus.ex_valid !== 1'b0) begin
      n_err++;
      $display("FAIL load_use_bubble: got ex_valid=%0b want 0", bus.ex_valid);
    end
    bus.fwd_mem_we = 1'b0; bus.fwd_mem_load = 1'b0;
    bus.fwd_wb_we = 1'b1; bus.fwd_wb_rd = 5'd7; bus.fwd_wb_data = 32'h1234;
    #1;
    n_cmp++;
    if (bus.id_ready !== 1'b1) begin
      n_err++;
      $display("FAIL load_use_release: got id_ready=%0b want 1", bus.id_ready);
    end
    tick();
    n_cmp++;
    if (bus.ex_valid !== 1'b1 || bus.ex_alu_b !== 32'h1234 || bus.ex_alu_a !== 32'h3) begin
      n_err++;
      $display("FAIL load_use_wb: got v=%0b a=%h b=%h want v=1 a=00000003 b=00001234",
               bus.ex_valid, bus.ex_alu_a, bus.ex_alu_b);
    end
    idle_inputs();
  endtask

  task automatic test_stall();
    bus.id_valid = 1'b1; bus.id_rs1 = 5'd1; bus.id_rs1_data = 32'h10; bus.id_rd = 5'd4;
    tick();
    bus.ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.id_rs1_data = 32'h500 + i; bus.id_rd = 5'd20 + 5'(i);
      #1;
      n_cmp++;
      if (bus.id_ready !== 1'b0) begin
        n_err++;
        $display("FAIL stall_ready_%0d: got id_ready=%0b want 0", i, bus.id_ready);
      end
      tick();
      n_cmp++;
      if (bus.ex_valid !== 1'b1 || bus.ex_alu_a !== 32'h10 || bus.ex_rd !== 5'd4) begin
        n_err++;
        $display("FAIL stall_hold_%0d: got v=%0b a=%h rd=%0d want v=1 a=00000010 rd=4",
                 i, bus.ex_valid, bus.ex_alu_a, bus.ex_rd);
      end
    end
    bus.ex_ready = 1'b1; bus.id_rs1_data = 32'h20; bus.id_rd = 5'd8;
    tick();
    n_cmp++;
    if (bus.ex_valid !== 1'b1 || bus.ex_alu_a !== 32'h20 || bus.ex_rd !== 5'd8) begin
      n_err++;
      $display("FAIL stall_release: got v=%0b a=%h rd=%0d want v=1 a=00000020 rd=8",
               bus.ex_valid, bus.ex_alu_a, bus.ex_rd);
    end
  endtask

  task automatic test_flush();
    // EX still holds a valid instruction from the previous test
    bus.ex_ready = 1'b0; bus.id_valid = 1'b1; bus.flush = 1'b1;
    bus.fwd_mem_we = 1'b1; bus.fwd_mem_load = 1'b1; bus.fwd_mem_rd = 5'd1;
    bus.id_rs1 = 5'd1; bus.id_rs1_used = 1'b1;
    #1;
    n_cmp++;
    if (bus.id_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flush_ready: got id_ready=%0b want 1", bus.id_ready);
    end
    tick();
    n_cmp++;
    if (bus.ex_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_squash: got ex_valid=%0b want 0", bus.ex_valid);
    end
    idle_inputs();
  endtask

  task automatic test_pc_imm_reset();
    bus.id_valid = 1'b1; bus.id_use_pc = 1'b1; bus.id_pc = 32'h100;
    bus.id_use_imm = 1'b1; bus.id_imm = 32'h2000;
    bus.id_rs1 = 5'd4; bus.id_rs1_data = 32'h44; bus.id_rs2 = 5'd4; bus.id_rs2_data = 32'h55;
    bus.fwd_mem_we = 1'b1; bus.fwd_mem_rd = 5'd4; bus.fwd_mem_data = 32'h99;
    bus.id_alu_op = EXE_OR_OP; bus.id_rd = 5'd12; bus.id_rd_we = 1'b1;
    tick();
    n_cmp++;
    if (bus.ex_valid !== 1'b1 || bus.ex_alu_a !== 32'h100 || bus.ex_alu_b !== 32'h2000) begin
      n_err++;
      $display("FAIL pc_imm: got v=%0b a=%h b=%h want v=1 a=00000100 b=00002000",
               bus.ex_valid, bus.ex_alu_a, bus.ex_alu_b);
    end
    bus.ex_ready = 1'b0; bus.id_pc = 32'h300;
    tick();
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if ({bus.ex_valid, bus.ex_alu_a, bus.ex_alu_b, bus.ex_alu_op, bus.ex_rd, bus.ex_rd_we} !== 75'd0) begin
      n_err++;
      $display("FAIL reset_mid_stall: got v=%0b a=%h b=%h op=%h rd=%0d we=%0b want all 0",
               bus.ex_valid, bus.ex_alu_a, bus.ex_alu_b, bus.ex_alu_op, bus.ex_rd, bus.ex_rd_we);
    end
    rst_n = 1'b1;
    bus.fwd_mem_we = 1'b0; bus.id_pc = 32'h400;
    #1;
    n_cmp++;
    if (bus.id_ready !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset_ready: got id_ready=%0b want 1", bus.id_ready);
    end
    tick();
    n_cmp++;
    if (bus.ex_valid !== 1'b1 || bus.ex_alu_a !== 32'h400) begin
      n_err++;
      $display("FAIL post_reset_accept: got v=%0b a=%h want v=1 a=00000400", bus.ex_valid, bus.ex_alu_a);
    end
    idle_inputs();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_fwd_priority();
    test_zero_reg();
    test_load_use();
    test_stall();
    test_flush();
    test_pc_imm_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  reset, active low.
REQ-002 SHALL have: id_valid  in  1  decode slot holds an instruction; id_ready  out  1  stage accepts it this cycle.
REQ-003 SHALL have: id_rs1, id_rs2  in  5  source register indices; id_rs1_used, id_rs2_used  in  1  source actually read.
REQ-004 SHALL have: id_rs1_data, id_rs2_data  in  32  register-file read data; id_imm  in  32  decoded immediate; id_pc  in  32  instruction PC.
REQ-005 SHALL have: id_use_pc  in  1  operand A = PC; id_use_imm  in  1  operand B = immediate; id_alu_op  in  4  ALU op code; id_rd  in  5; id_rd_we  in  1.
REQ-006 SHALL have: fwd_mem_we, fwd_mem_load  in  1; fwd_mem_rd  in  5; fwd_mem_data  in  32  (MEM-stage producer). Also fwd_wb_we  in  1; fwd_wb_rd  in  5; fwd_wb_data  in  32  (WB-stage producer).
REQ-007 SHALL have: flush  in  1  squash stage content; ex_ready  in  1  ALU/EX consumer accepts.
REQ-008 SHALL have: ex_valid  out  1; ex_alu_a, ex_alu_b  out  32; ex_alu_op  out  4; ex_rd  out  5; ex_rd_we  out  1; all registered.

Function
REQ-009 SHALL resolve each source as: MEM data if fwd_mem_we, rd match, rd!=0; else WB data if fwd_wb_we, rd match, rd!=0; else register-file data.
REQ-010 SHALL never forward for index 0; source 0 always yields register-file data.
REQ-011 SHALL select operand A = id_pc if id_use_pc, else resolved rs1. Operand B = id_imm if id_use_imm, else resolved rs2.
REQ-012 SHALL detect load-use hazard = fwd_mem_we & fwd_mem_load & fwd_mem_rd!=0 & ((id_rs1_used & rs1==fwd_mem_rd) | (id_rs2_used & rs2==fwd_mem_rd)).
REQ-013 SHALL drive id_ready = flush | ((~ex_valid | ex_ready) & ~hazard), combinationally.
REQ-014 SHALL define a transfer as id_valid & id_ready & ~flush. On transfer, capture operands, op, rd, rd_we at the clock edge and set ex_valid=1. Latency: one cycle.
REQ-015 When (~ex_valid | ex_ready) holds and there is no transfer, SHALL clear ex_valid at the edge (bubble insertion, including during a hazard).
REQ-016 When ex_valid & ~ex_ready, SHALL hold all outputs stable. Upstream inputs are ignored.
REQ-017 Flush SHALL win over every other event. At the edge, ex_valid<=0 and the incoming instruction is discarded, even if hazard or ex_ready is low.
REQ-018 Payload registers MAY retain old values while ex_valid=0. Consumers SHALL qualify with ex_valid.
REQ-019 When both MEM and WB match the same index, SHALL select MEM (youngest producer).
REQ-020 A hazard SHALL take priority over forwarding. No instruction is captured with forwarded load data from MEM.
REQ-021 Arithmetic: none. Width is 32 throughout; op code passes through unmodified.

Reset
REQ-022 While rst_n=0 at a clock edge, SHALL set ex_valid=0, ex_alu_a=0, ex_alu_b=0, ex_alu_op=0, ex_rd=0, ex_rd_we=0.
REQ-023 Reset asserted mid-stall SHALL discard the held instruction. The first cycle after release SHALL accept a new one if no hazard.
REQ-024 id_ready is combinational and SHALL follow REQ-013 using reset register values (ex_valid=0).

Structure
REQ-025 ALU op encodings SHALL remain the shared EXE_*_OP defines.
REQ-026 A forwarding-select enum (FWD_RF, FWD_MEM, FWD_WB) SHALL live in the shared core package.
REQ-027 SHALL instantiate a sub-module fwd_mux twice (rs1, rs2). Inputs: index, rf data, both producer ports. Outputs: resolved data and select.

Verification
REQ-028 rs1=5 rf=0x11, MEM we rd=5 data=0xAA, WB we rd=5 data=0xBB, add -> next cycle ex_alu_a=0xAA, ex_valid=1.
REQ-029 rs1=0, MEM we rd=0 data=0xFF, rf=0 -> ex_alu_a=0x0.
REQ-030 MEM load rd=7, id rs2=7 used, id_valid=1 -> id_ready=0, ex_valid=0 next cycle. Then load drops, WB rd=7 data=0x1234 -> ex_alu_b=0x1234.
REQ-031 ex_valid=1, ex_ready=0 for 3 cycles, id inputs changing -> outputs unchanged, id_ready=0. ex_ready=1 -> next instruction captured.
REQ-032 flush=1 with id_valid=1 and ex_ready=0 -> id_ready=1, ex_valid=0 next cycle.
REQ-033 use_pc=1 pc=0x100 use_imm=1 imm=0x2000 -> ex_alu_a=0x100, ex_alu_b=0x2000. rst_n=0 mid-stall -> all outputs 0.
